// File: rtl/mem_fetch_interface.sv
// Byte-addressable big-endian RAM with a multi-cycle IDLE/BUSY/DONE access controller and MFC handshake.
// Optional MEM_ALIGN_CHECK_EN adds align_err and suppresses misaligned accesses instead of force-aligning them.
module mem_fetch_interface #(
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  memEn,
  input  logic                  memRW,
  input  logic [1:0]            dataType,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  mfc
`ifdef MEM_ALIGN_CHECK_EN
  ,output logic                 align_err
`endif
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_rw;
  logic [1:0]            r_type;
  logic [31:0]           r_din;
  logic [7:0]            r_mem [DEPTH];

  logic [ADDR_WIDTH-1:0] w_addr_al;
  logic [ADDR_WIDTH-1:0] w_a1;
  logic [ADDR_WIDTH-1:0] w_a2;
  logic [ADDR_WIDTH-1:0] w_a3;
  logic [31:0]           w_rdata;
  logic                  w_ok;
  logic                  w_access;
  logic                  w_we;

`ifdef MEM_ALIGN_CHECK_EN
  logic r_mis;
  logic w_mis_in;
  assign w_mis_in = ((dataType == 2'b01) && address[0]) ||
                    (dataType[1] && (address[1:0] != 2'b00));
  assign w_ok     = !r_mis;
`else
  assign w_ok     = 1'b1;
`endif

  // Low address bits are dropped at latch time so the access always lands on a natural boundary.
  always_comb begin
    w_addr_al = address;
    case (dataType)
      2'b00:   w_addr_al = address;
      2'b01:   w_addr_al[0] = 1'b0;
      default: w_addr_al[1:0] = 2'b00;
    endcase
  end

  assign w_a1 = r_addr + ADDR_WIDTH'(1);
  assign w_a2 = r_addr + ADDR_WIDTH'(2);
  assign w_a3 = r_addr + ADDR_WIDTH'(3);

  always_comb begin
    case (r_type)
      2'b00:   w_rdata = {24'h0, r_mem[r_addr]};
      2'b01:   w_rdata = {16'h0, r_mem[r_addr], r_mem[w_a1]};
      default: w_rdata = {r_mem[r_addr], r_mem[w_a1], r_mem[w_a2], r_mem[w_a3]};
    endcase
  end

  assign w_access = (r_state == S_BUSY) && (r_cnt == 4'd0);
  // Gating with clr drops a write that would otherwise land on the same edge as a reset.
  assign w_we     = w_access && !r_rw && w_ok && !clr;

  always_ff @(posedge clk) begin
    if (w_we) begin
      case (r_type)
        2'b00: r_mem[r_addr] <= r_din[7:0];
        2'b01: begin
          r_mem[r_addr] <= r_din[15:8];
          r_mem[w_a1]   <= r_din[7:0];
        end
        default: begin
          r_mem[r_addr] <= r_din[31:24];
          r_mem[w_a1]   <= r_din[23:16];
          r_mem[w_a2]   <= r_din[15:8];
          r_mem[w_a3]   <= r_din[7:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_type   <= 2'b00;
      r_din    <= 32'h0;
      mfc      <= 1'b0;
      data_out <= 32'h0;
`ifdef MEM_ALIGN_CHECK_EN
      r_mis     <= 1'b0;
      align_err <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (memEn) begin
            r_addr  <= w_addr_al;
            r_rw    <= memRW;
            r_type  <= dataType;
            r_din   <= data_in;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_state <= S_BUSY;
`ifdef MEM_ALIGN_CHECK_EN
            r_mis   <= w_mis_in;
`endif
          end
        end
        S_BUSY: begin
          if (r_cnt == 4'd0) begin
            r_state <= S_DONE;
            mfc     <= 1'b1;
            if (r_rw && w_ok) data_out <= w_rdata;
`ifdef MEM_ALIGN_CHECK_EN
            align_err <= r_mis;
`endif
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_DONE: begin
          if (!memEn) begin
            r_state <= S_IDLE;
            mfc     <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err <= 1'b0;
`endif
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
